// File: rtl/drop_controller.sv
// drop_controller: write side of the connect-four board encoding.
// Scans the chosen column bottom-up and places the current player's piece.
module drop_controller #(
  parameter int COLS = 7,
  parameter int ROWS = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   drop_valid,
  input  logic [2:0]             drop_col,
  output logic                   drop_ready,
  output logic [COLS*ROWS-1:0]   red_enc,
  output logic [COLS*ROWS-1:0]   yel_enc,
  output logic                   turn,
  output logic                   drop_done,
  output logic                   drop_err,
  output logic [5:0]             last_pos,
  output logic                   board_full
);

  localparam int CELLS = COLS * ROWS;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE,
    ERR
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [2:0]         r_col;
  logic [2:0]         w_col_nxt;
  logic [2:0]         r_row;
  logic [2:0]         w_row_nxt;
  logic [CELLS-1:0]   r_red;
  logic [CELLS-1:0]   w_red_nxt;
  logic [CELLS-1:0]   r_yel;
  logic [CELLS-1:0]   w_yel_nxt;
  logic               r_turn;
  logic               w_turn_nxt;
  logic [5:0]         r_last;
  logic [5:0]         w_last_nxt;
  logic               r_done;
  logic               w_done_nxt;
  logic               r_err;
  logic               w_err_nxt;

  logic [CELLS-1:0]   w_occ;
  logic               w_full;
  logic               w_ready;
  logic [5:0]         w_row6;
  logic [5:0]         w_idx;
  logic [CELLS-1:0]   w_bit;
  logic               w_hit;
  logic               w_bad_col;

  // Occupancy, fullness and the cell currently under the scan pointer
  always_comb begin
    w_occ     = r_red | r_yel;
    w_full    = &w_occ;
    w_ready   = (r_state == IDLE) && !w_full;
    w_row6    = {3'b000, r_row};
    w_idx     = {3'b000, r_col} + w_row6 * 6'(COLS);
    w_bit     = {{(CELLS-1){1'b0}}, 1'b1} << w_idx;
    w_hit     = |(w_occ & w_bit);
    w_bad_col = drop_col > 3'(COLS - 1);
  end

  // Next-state and datapath updates; clear overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_red_nxt   = r_red;
    w_yel_nxt   = r_yel;
    w_turn_nxt  = r_turn;
    w_last_nxt  = r_last;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    if (clear) begin
      w_state_nxt = IDLE;
      w_col_nxt   = '0;
      w_row_nxt   = '0;
      w_red_nxt   = '0;
      w_yel_nxt   = '0;
      w_turn_nxt  = 1'b0;
      w_last_nxt  = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (drop_valid && w_ready) begin
            if (w_bad_col) begin
              w_state_nxt = ERR;
            end else begin
              w_col_nxt   = drop_col;
              w_row_nxt   = 3'(ROWS - 1);
              w_state_nxt = SCAN;
            end
          end
        end
        SCAN: begin
          if (!w_hit) begin
            if (r_turn) begin
              w_yel_nxt = r_yel | w_bit;
            end else begin
              w_red_nxt = r_red | w_bit;
            end
            w_last_nxt  = w_idx;
            w_turn_nxt  = ~r_turn;
            w_done_nxt  = 1'b1;
            w_state_nxt = DONE;
          end else if (r_row == 3'd0) begin
            w_state_nxt = ERR;
          end else begin
            w_row_nxt = r_row - 3'd1;
          end
        end
        DONE: begin
          w_state_nxt = IDLE;
        end
        ERR: begin
          w_err_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // State and board registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_col   <= '0;
      r_row   <= '0;
      r_red   <= '0;
      r_yel   <= '0;
      r_turn  <= 1'b0;
      r_last  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
      r_red   <= w_red_nxt;
      r_yel   <= w_yel_nxt;
      r_turn  <= w_turn_nxt;
      r_last  <= w_last_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign drop_ready = w_ready;
  assign board_full = w_full;
  assign red_enc    = r_red;
  assign yel_enc    = r_yel;
  assign turn       = r_turn;
  assign last_pos   = r_last;
  assign drop_done  = r_done;
  assign drop_err   = r_err;

endmodule

// File: tb/tb_drop_controller.sv
// tb_drop_controller: randomized drops checked against a board model.
// Model tracks column heights and derives cells and pulse timing from them.
module tb_drop_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        drop_valid;
  logic [2:0]  drop_col;
  logic        drop_ready;
  logic [41:0] red_enc;
  logic [41:0] yel_enc;
  logic        turn;
  logic        drop_done;
  logic        drop_err;
  logic [5:0]  last_pos;
  logic        board_full;

  int checks = 0;
  int failures = 0;

  int          height[7];
  logic [41:0] m_red;
  logic [41:0] m_yel;
  logic        m_turn;
  logic [5:0]  m_last;

  drop_controller dut (
    .clk(clk), .reset(reset), .clear(clear),
    .drop_valid(drop_valid), .drop_col(drop_col),
    .drop_ready(drop_ready), .red_enc(red_enc),
    .yel_enc(yel_enc), .turn(turn),
    .drop_done(drop_done), .drop_err(drop_err),
    .last_pos(last_pos), .board_full(board_full)
  );

  always #5 clk = ~clk;

  task automatic m_reset();
    for (int i = 0; i < 7; i++) height[i] = 0;
    m_red = '0;
    m_yel = '0;
    m_turn = 1'b0;
    m_last = '0;
  endtask

  // Gravity model: k pieces in column c -> lands in row 5-k
  task automatic m_drop(input int c, output int ed, output int ee);
    int k;
    int idx;
    ed = -1;
    ee = -1;
    if (c > 6) begin
      ee = 1;
    end else begin
      k = height[c];
      if (k == 6) begin
        ee = 7;
      end else begin
        idx = c + 7 * (5 - k);
        if (m_turn) m_yel[idx] = 1'b1;
        else m_red[idx] = 1'b1;
        m_last = 6'(idx);
        m_turn = ~m_turn;
        height[c] = k + 1;
        ed = 1 + k;
      end
    end
  endtask

  // Present one drop and record in which cycle each pulse appears
  task automatic drop(input int c, output int d_at, output int e_at,
                      output int nd, output int ne);
    d_at = -1;
    e_at = -1;
    nd = 0;
    ne = 0;
    @(negedge clk);
    drop_valid = 1'b1;
    drop_col = 3'(c);
    @(posedge clk);
    @(negedge clk);
    drop_valid = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (drop_done === 1'b1) begin
        nd++;
        if (d_at < 0) d_at = n;
      end
      if (drop_err === 1'b1) begin
        ne++;
        if (e_at < 0) e_at = n;
      end
      if (n < 9) @(negedge clk);
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear = 1'b0;
    drop_valid = 1'b0;
    drop_col = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_reset();
    @(negedge clk);
    checks++;
    if (red_enc !== '0 || yel_enc !== '0) begin
      failures++;
      $display("FAIL reset_enc got=%h/%h exp=0/0", red_enc, yel_enc);
    end
    checks++;
    if (turn !== 1'b0 || last_pos !== 6'd0) begin
      failures++;
      $display("FAIL reset_turn_last got=%b/%0d exp=0/0", turn, last_pos);
    end
    checks++;
    if (drop_done !== 1'b0 || drop_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_pulses got=%b/%b exp=0/0", drop_done, drop_err);
    end
    checks++;
    if (drop_ready !== 1'b1 || board_full !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready got=%b/%b exp=1/0", drop_ready, board_full);
    end
  endtask

  task automatic test_first_drops();
    int ed, ee, d, e, nd, ne;
    m_drop(3, ed, ee);
    drop(3, d, e, nd, ne);
    checks++;
    if (d !== 1 || nd !== 1 || ne !== 0) begin
      failures++;
      $display("FAIL first_done got=%0d/%0d/%0d exp=1/1/0", d, nd, ne);
    end
    checks++;
    if (red_enc !== m_red || yel_enc !== '0) begin
      failures++;
      $display("FAIL first_enc got=%h/%h exp=%h/0", red_enc, yel_enc, m_red);
    end
    checks++;
    if (turn !== 1'b1 || last_pos !== 6'd38) begin
      failures++;
      $display("FAIL first_turn_last got=%b/%0d exp=1/38", turn, last_pos);
    end
    m_drop(3, ed, ee);
    drop(3, d, e, nd, ne);
    checks++;
    if (d !== ed || d !== 2 || nd !== 1 || ne !== 0) begin
      failures++;
      $display("FAIL second_done got=%0d/%0d exp=2/1", d, nd);
    end
    checks++;
    if (yel_enc !== m_yel || yel_enc[31] !== 1'b1 || red_enc !== m_red) begin
      failures++;
      $display("FAIL second_enc got=%h/%h exp=%h/%h", red_enc, yel_enc, m_red, m_yel);
    end
    checks++;
    if (turn !== 1'b0 || last_pos !== 6'd31) begin
      failures++;
      $display("FAIL second_turn_last got=%b/%0d exp=0/31", turn, last_pos);
    end
  endtask

  task automatic test_full_column();
    int ed, ee, d, e, nd, ne;
    do_clear();
    for (int i = 0; i < 6; i++) begin
      m_drop(0, ed, ee);
      drop(0, d, e, nd, ne);
      checks++;
      if (d !== ed || nd !== 1 || ne !== 0) begin
        failures++;
        $display("FAIL fill_col0 drop=%0d got=%0d exp=%0d", i, d, ed);
      end
    end
    m_drop(0, ed, ee);
    drop(0, d, e, nd, ne);
    checks++;
    if (e !== 7 || ee !== 7 || ne !== 1 || nd !== 0) begin
      failures++;
      $display("FAIL full_col_err got=%0d/%0d/%0d exp=7/1/0", e, ne, nd);
    end
    checks++;
    if (red_enc !== m_red || yel_enc !== m_yel || turn !== m_turn) begin
      failures++;
      $display("FAIL full_col_state got=%h/%h/%b exp=%h/%h/%b",
               red_enc, yel_enc, turn, m_red, m_yel, m_turn);
    end
    checks++;
    if (drop_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_col_ready got=%b exp=1", drop_ready);
    end
  endtask

  task automatic test_invalid_col();
    int ed, ee, d, e, nd, ne;
    m_drop(7, ed, ee);
    drop(7, d, e, nd, ne);
    checks++;
    if (e !== 1 || ne !== 1 || nd !== 0) begin
      failures++;
      $display("FAIL invalid_err got=%0d/%0d/%0d exp=1/1/0", e, ne, nd);
    end
    checks++;
    if (red_enc !== m_red || yel_enc !== m_yel || turn !== m_turn || last_pos !== m_last) begin
      failures++;
      $display("FAIL invalid_state got=%h/%h/%b/%0d exp=%h/%h/%b/%0d",
               red_enc, yel_enc, turn, last_pos, m_red, m_yel, m_turn, m_last);
    end
  endtask

  task automatic test_clear_mid_scan();
    int ed, ee, d, e, nd, ne;
    int pulses;
    do_clear();
    for (int i = 0; i < 3; i++) begin
      m_drop(5, ed, ee);
      drop(5, d, e, nd, ne);
    end
    @(negedge clk);
    drop_valid = 1'b1;
    drop_col = 3'd5;
    @(posedge clk);
    @(negedge clk);
    drop_valid = 1'b0;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_reset();
    checks++;
    if (red_enc !== '0 || yel_enc !== '0 || turn !== 1'b0 || last_pos !== 6'd0) begin
      failures++;
      $display("FAIL clear_state got=%h/%h/%b/%0d exp=0/0/0/0", red_enc, yel_enc, turn, last_pos);
    end
    checks++;
    if (drop_ready !== 1'b1) begin
      failures++;
      $display("FAIL clear_ready got=%b exp=1", drop_ready);
    end
    pulses = 0;
    for (int n = 0; n < 8; n++) begin
      if (drop_done === 1'b1 || drop_err === 1'b1) pulses++;
      @(negedge clk);
    end
    checks++;
    if (pulses !== 0 || red_enc !== '0 || yel_enc !== '0) begin
      failures++;
      $display("FAIL clear_no_pulse got=%0d exp=0", pulses);
    end
  endtask

  task automatic test_random();
    int ed, ee, d, e, nd, ne, c;
    do_clear();
    for (int i = 0; i < 40; i++) begin
      c = int'($urandom_range(0, 7));
      m_drop(c, ed, ee);
      drop(c, d, e, nd, ne);
      checks++;
      if (d !== ed || e !== ee || nd + ne !== 1) begin
        failures++;
        $display("FAIL rand_timing i=%0d col=%0d got=%0d/%0d exp=%0d/%0d", i, c, d, e, ed, ee);
      end
      checks++;
      if (red_enc !== m_red || yel_enc !== m_yel || turn !== m_turn || last_pos !== m_last) begin
        failures++;
        $display("FAIL rand_state i=%0d got=%h/%h/%b/%0d exp=%h/%h/%b/%0d", i,
                 red_enc, yel_enc, turn, last_pos, m_red, m_yel, m_turn, m_last);
      end
    end
  endtask

  task automatic test_fill_board();
    int ed, ee, d, e, nd, ne, c;
    int pulses;
    do_clear();
    for (int i = 0; i < 42; i++) begin
      do c = int'($urandom_range(0, 6)); while (height[c] == 6);
      m_drop(c, ed, ee);
      drop(c, d, e, nd, ne);
      checks++;
      if (d !== ed || nd !== 1 || red_enc !== m_red || yel_enc !== m_yel) begin
        failures++;
        $display("FAIL fill_drop i=%0d col=%0d got=%0d exp=%0d", i, c, d, ed);
      end
    end
    checks++;
    if (board_full !== 1'b1 || drop_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_flags got=%b/%b exp=1/0", board_full, drop_ready);
    end
    checks++;
    if ((red_enc | yel_enc) !== {42{1'b1}} || (red_enc & yel_enc) !== '0) begin
      failures++;
      $display("FAIL full_enc got=%h/%h", red_enc, yel_enc);
    end
    @(negedge clk);
    drop_valid = 1'b1;
    drop_col = 3'd2;
    pulses = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (drop_done === 1'b1 || drop_err === 1'b1) pulses++;
    end
    drop_valid = 1'b0;
    checks++;
    if (pulses !== 0 || red_enc !== m_red || yel_enc !== m_yel || turn !== m_turn) begin
      failures++;
      $display("FAIL full_ignore got=%0d pulses exp=0", pulses);
    end
  endtask

  task automatic test_async_reset();
    int ed, ee, d, e, nd, ne;
    do_clear();
    for (int i = 0; i < 5; i++) begin
      m_drop(2, ed, ee);
      drop(2, d, e, nd, ne);
    end
    @(negedge clk);
    drop_valid = 1'b1;
    drop_col = 3'd2;
    @(posedge clk);
    @(negedge clk);
    drop_valid = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (red_enc !== '0 || yel_enc !== '0 || turn !== 1'b0 || last_pos !== 6'd0) begin
      failures++;
      $display("FAIL async_reset got=%h/%h/%b/%0d exp=0/0/0/0", red_enc, yel_enc, turn, last_pos);
    end
    checks++;
    if (drop_done !== 1'b0 || drop_err !== 1'b0 || drop_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset_ctl got=%b/%b/%b exp=0/0/1", drop_done, drop_err, drop_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    m_drop(1, ed, ee);
    drop(1, d, e, nd, ne);
    checks++;
    if (d !== ed || nd !== 1 || red_enc !== m_red || last_pos !== m_last) begin
      failures++;
      $display("FAIL after_reset got=%0d/%0d exp=%0d/%0d", d, last_pos, ed, m_last);
    end
  endtask

  initial begin
    test_reset();
    test_first_drops();
    test_full_column();
    test_invalid_col();
    test_clear_mid_scan();
    test_random();
    test_fill_board();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
